// File: rtl/ddr_frame_buf_sched.sv
// Triple-buffer frame scheduler issuing DDR mover write/read jobs in the ACLK domain.
// Optional write-job watchdog: define SCHED_WDOG_EN.
module ddr_frame_buf_sched #(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter logic [31:0] BUF_STRIDE  = 32'h0010_0000,
   parameter logic [31:0] FRAME_BYTES = 32'd614400,
   parameter logic [23:0] WDOG_CYCLES = 24'd2000000
) (
   input  logic        ACLK,
   input  logic        ARESETN,
   input  logic        ENABLE,
   input  logic        WR_FRAME_SYNC,
   input  logic        RD_FRAME_SYNC,
   output logic        WR_START,
   output logic [31:0] WR_ADRS,
   output logic [31:0] WR_LEN,
   input  logic        WR_READY,
   input  logic        WR_DONE,
   output logic        MASTER_RST,
   output logic        RD_START,
   output logic [31:0] RD_ADRS,
   output logic [31:0] RD_LEN,
   input  logic        RD_READY,
   input  logic        RD_DONE,
   output logic [1:0]  WR_BUF_IDX,
   output logic [1:0]  RD_BUF_IDX,
   output logic        FRAME_VALID,
   output logic [15:0] DROP_CNT,
   output logic [15:0] REPEAT_CNT,
   output logic        ERR
);

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_BUSY = 2'd1, W_ABORT = 2'd2} wr_state_t;
   typedef enum logic {R_IDLE = 1'b0, R_BUSY = 1'b1} rd_state_t;

   wr_state_t   wr_state_q, wr_state_d;
   rd_state_t   rd_state_q, rd_state_d;
   logic [1:0]  latest_q, latest_d, rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
   logic [1:0]  wr_buf_idx_q, wr_buf_idx_d, wr_pick_s;
   logic        frame_valid_q, frame_valid_d, wr_start_q, wr_start_d;
   logic        rd_start_q, rd_start_d, master_rst_q, master_rst_d;
   logic [31:0] wr_adrs_q, wr_adrs_d, wr_len_q, wr_len_d;
   logic [31:0] rd_adrs_q, rd_adrs_d, rd_len_q, rd_len_d;
   logic [15:0] drop_q, drop_d, repeat_q, repeat_d;
`ifdef SCHED_WDOG_EN
   logic [23:0] wdog_q, wdog_d;
   logic        err_q, err_d;
`endif

   // Lowest index clear of both the newest frame and the buffer on display.
   function automatic logic [1:0] pick_free(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] r;
      if (a != 2'd0 && b != 2'd0) begin
         r = 2'd0;
      end else if (a != 2'd1 && b != 2'd1) begin
         r = 2'd1;
      end else begin
         r = 2'd2;
      end
      return r;
   endfunction

   function automatic logic [31:0] buf_addr(input logic [1:0] idx);
      return BASE_ADDR + BUF_STRIDE * {30'd0, idx};
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   assign wr_pick_s = pick_free(latest_q, rd_idx_q);

   // Write FSM: job launch, completion, drop counting and abort.
   always_comb begin
      wr_state_d    = wr_state_q;
      wr_idx_d      = wr_idx_q;
      wr_buf_idx_d  = wr_buf_idx_q;
      latest_d      = latest_q;
      frame_valid_d = frame_valid_q;
      wr_start_d    = 1'b0;
      master_rst_d  = 1'b0;
      wr_adrs_d     = wr_adrs_q;
      wr_len_d      = wr_len_q;
      drop_d        = drop_q;
`ifdef SCHED_WDOG_EN
      wdog_d        = wdog_q;
      err_d         = err_q;
`endif
      case (wr_state_q)
         W_IDLE: begin
            if (WR_FRAME_SYNC && ENABLE && WR_READY) begin
               wr_idx_d     = wr_pick_s;
               wr_buf_idx_d = wr_pick_s;
               wr_adrs_d    = buf_addr(wr_pick_s);
               wr_len_d     = FRAME_BYTES;
               wr_start_d   = 1'b1;
               wr_state_d   = W_BUSY;
`ifdef SCHED_WDOG_EN
               wdog_d       = 24'd0;
`endif
            end else if (WR_FRAME_SYNC) begin
               drop_d = sat_inc(drop_q);
            end else begin
               drop_d = drop_q;
            end
         end
         W_BUSY: begin
            if (WR_FRAME_SYNC) begin
               drop_d = sat_inc(drop_q);
            end else begin
               drop_d = drop_q;
            end
            // Completion wins over a same-cycle abort condition.
            if (WR_DONE) begin
               latest_d      = wr_idx_q;
               frame_valid_d = 1'b1;
               wr_state_d    = W_IDLE;
            end else if (!ENABLE) begin
               master_rst_d = 1'b1;
               wr_state_d   = W_ABORT;
            end
`ifdef SCHED_WDOG_EN
            else if (wdog_q == WDOG_CYCLES - 24'd1) begin
               master_rst_d = 1'b1;
               err_d        = 1'b1;
               wr_state_d   = W_ABORT;
            end else begin
               wdog_d = wdog_q + 24'd1;
            end
`else
            else begin
               wr_state_d = W_BUSY;
            end
`endif
         end
         W_ABORT: begin
            if (WR_FRAME_SYNC) begin
               drop_d = sat_inc(drop_q);
            end else begin
               drop_d = drop_q;
            end
            wr_state_d = W_IDLE;
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   // Read FSM: always hands the newest complete frame to the mover.
   always_comb begin
      rd_state_d = rd_state_q;
      rd_idx_d   = rd_idx_q;
      rd_start_d = 1'b0;
      rd_adrs_d  = rd_adrs_q;
      rd_len_d   = rd_len_q;
      repeat_d   = repeat_q;
      case (rd_state_q)
         R_IDLE: begin
            if (RD_FRAME_SYNC && ENABLE && RD_READY && frame_valid_q) begin
               rd_idx_d   = latest_q;
               rd_adrs_d  = buf_addr(latest_q);
               rd_len_d   = FRAME_BYTES;
               rd_start_d = 1'b1;
               rd_state_d = R_BUSY;
               if (latest_q == rd_idx_q) begin
                  repeat_d = sat_inc(repeat_q);
               end else begin
                  repeat_d = repeat_q;
               end
            end else if (RD_FRAME_SYNC) begin
               repeat_d = sat_inc(repeat_q);
            end else begin
               repeat_d = repeat_q;
            end
         end
         R_BUSY: begin
            if (RD_FRAME_SYNC) begin
               repeat_d = sat_inc(repeat_q);
            end else begin
               repeat_d = repeat_q;
            end
            if (RD_DONE) begin
               rd_state_d = R_IDLE;
            end else begin
               rd_state_d = R_BUSY;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_state_q    <= W_IDLE;
         rd_state_q    <= R_IDLE;
         latest_q      <= 2'd0;
         rd_idx_q      <= 2'd0;
         wr_idx_q      <= 2'd1;
         wr_buf_idx_q  <= 2'd0;
         frame_valid_q <= 1'b0;
         wr_start_q    <= 1'b0;
         rd_start_q    <= 1'b0;
         master_rst_q  <= 1'b0;
         wr_adrs_q     <= 32'd0;
         wr_len_q      <= 32'd0;
         rd_adrs_q     <= 32'd0;
         rd_len_q      <= 32'd0;
         drop_q        <= 16'd0;
         repeat_q      <= 16'd0;
`ifdef SCHED_WDOG_EN
         wdog_q        <= 24'd0;
         err_q         <= 1'b0;
`endif
      end else begin
         wr_state_q    <= wr_state_d;
         rd_state_q    <= rd_state_d;
         latest_q      <= latest_d;
         rd_idx_q      <= rd_idx_d;
         wr_idx_q      <= wr_idx_d;
         wr_buf_idx_q  <= wr_buf_idx_d;
         frame_valid_q <= frame_valid_d;
         wr_start_q    <= wr_start_d;
         rd_start_q    <= rd_start_d;
         master_rst_q  <= master_rst_d;
         wr_adrs_q     <= wr_adrs_d;
         wr_len_q      <= wr_len_d;
         rd_adrs_q     <= rd_adrs_d;
         rd_len_q      <= rd_len_d;
         drop_q        <= drop_d;
         repeat_q      <= repeat_d;
`ifdef SCHED_WDOG_EN
         wdog_q        <= wdog_d;
         err_q         <= err_d;
`endif
      end
   end

   assign WR_START    = wr_start_q;
   assign WR_ADRS     = wr_adrs_q;
   assign WR_LEN      = wr_len_q;
   assign MASTER_RST  = master_rst_q;
   assign RD_START    = rd_start_q;
   assign RD_ADRS     = rd_adrs_q;
   assign RD_LEN      = rd_len_q;
   assign WR_BUF_IDX  = wr_buf_idx_q;
   assign RD_BUF_IDX  = rd_idx_q;
   assign FRAME_VALID = frame_valid_q;
   assign DROP_CNT    = drop_q;
   assign REPEAT_CNT  = repeat_q;
`ifdef SCHED_WDOG_EN
   assign ERR         = err_q;
`else
   assign ERR         = 1'b0;
`endif

   ddr_frame_buf_sched_chk #(.WDOG_CYCLES(WDOG_CYCLES)) u_chk (
      .ACLK     (ACLK),
      .ARESETN  (ARESETN),
      .wr_busy_i(wr_state_q == W_BUSY),
      .rd_busy_i(rd_state_q == R_BUSY),
      .wr_idx_i (wr_idx_q),
      .rd_idx_i (rd_idx_q)
   );

endmodule

// Buffer-exclusion checks for the scheduler.
module ddr_frame_buf_sched_chk #(
   parameter logic [23:0] WDOG_CYCLES = 24'd2000000
) (
   input logic       ACLK,
   input logic       ARESETN,
   input logic       wr_busy_i,
   input logic       rd_busy_i,
   input logic [1:0] wr_idx_i,
   input logic [1:0] rd_idx_i
);

   a_no_shared_buf: assert property (@(posedge ACLK) disable iff (!ARESETN)
      (wr_busy_i && rd_busy_i) |-> (wr_idx_i != rd_idx_i));

   a_wdog_nonzero: assert property (@(posedge ACLK) disable iff (!ARESETN)
      WDOG_CYCLES != 24'd0);

endmodule

// File: tb/tb_ddr_frame_buf_sched.sv
// Directed self-checking bench for ddr_frame_buf_sched (default build).
module tb_ddr_frame_buf_sched;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        enable = 1'b0;
   logic        wr_frame_sync = 1'b0;
   logic        rd_frame_sync = 1'b0;
   logic        wr_ready = 1'b1;
   logic        wr_done = 1'b0;
   logic        rd_ready = 1'b1;
   logic        rd_done = 1'b0;
   logic        wr_start, master_rst, rd_start, frame_valid, err;
   logic [31:0] wr_adrs, wr_len, rd_adrs, rd_len;
   logic [1:0]  wr_buf_idx, rd_buf_idx;
   logic [15:0] drop_cnt, repeat_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] adr_tab [3];
   logic [1:0]  wr_seq  [5];

   always #5 aclk = ~aclk;

   ddr_frame_buf_sched dut (
      .ACLK(aclk), .ARESETN(aresetn), .ENABLE(enable),
      .WR_FRAME_SYNC(wr_frame_sync), .RD_FRAME_SYNC(rd_frame_sync),
      .WR_START(wr_start), .WR_ADRS(wr_adrs), .WR_LEN(wr_len),
      .WR_READY(wr_ready), .WR_DONE(wr_done), .MASTER_RST(master_rst),
      .RD_START(rd_start), .RD_ADRS(rd_adrs), .RD_LEN(rd_len),
      .RD_READY(rd_ready), .RD_DONE(rd_done),
      .WR_BUF_IDX(wr_buf_idx), .RD_BUF_IDX(rd_buf_idx),
      .FRAME_VALID(frame_valid), .DROP_CNT(drop_cnt),
      .REPEAT_CNT(repeat_cnt), .ERR(err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic pulse_wr_sync();
      wr_frame_sync = 1'b1; step(); wr_frame_sync = 1'b0;
   endtask

   task automatic pulse_wr_done();
      wr_done = 1'b1; step(); wr_done = 1'b0;
   endtask

   task automatic pulse_rd_sync();
      rd_frame_sync = 1'b1; step(); rd_frame_sync = 1'b0;
   endtask

   task automatic pulse_rd_done();
      rd_done = 1'b1; step(); rd_done = 1'b0;
   endtask

   initial begin
      adr_tab[0] = 32'h1000_0000;
      adr_tab[1] = 32'h1010_0000;
      adr_tab[2] = 32'h1020_0000;
      wr_seq[0] = 2'd0; wr_seq[1] = 2'd2; wr_seq[2] = 2'd0;
      wr_seq[3] = 2'd2; wr_seq[4] = 2'd0;

      step(); step();
      chk("rst_wr_start", {31'd0, wr_start}, 32'd0);
      chk("rst_wr_adrs", wr_adrs, 32'd0);
      chk("rst_wr_len", wr_len, 32'd0);
      chk("rst_rd_adrs", rd_adrs, 32'd0);
      chk("rst_bufidx", {28'd0, wr_buf_idx, rd_buf_idx}, 32'd0);
      chk("rst_flags", {28'd0, frame_valid, master_rst, rd_start, err}, 32'd0);
      chk("rst_counts", {drop_cnt, repeat_cnt}, 32'd0);
      aresetn = 1'b1;
      enable  = 1'b1;
      step();

      // Read sync with no complete frame: ignored but counted.
      pulse_rd_sync();
      chk("norframe_rd_start", {31'd0, rd_start}, 32'd0);
      chk("norframe_repeat", {16'd0, repeat_cnt}, 32'd1);

      // First write goes to buffer 1.
      pulse_wr_sync();
      chk("w1_start", {31'd0, wr_start}, 32'd1);
      chk("w1_adrs", wr_adrs, 32'h1010_0000);
      chk("w1_len", wr_len, 32'd614400);
      chk("w1_idx", {30'd0, wr_buf_idx}, 32'd1);
      chk("w1_fv_before_done", {31'd0, frame_valid}, 32'd0);

      // Sync while busy is dropped with no extra launch.
      pulse_wr_sync();
      chk("busy_sync_no_start", {31'd0, wr_start}, 32'd0);
      chk("busy_sync_drop", {16'd0, drop_cnt}, 32'd1);

      pulse_wr_done();
      chk("w1_done_fv", {31'd0, frame_valid}, 32'd1);

      pulse_rd_sync();
      chk("r1_start", {31'd0, rd_start}, 32'd1);
      chk("r1_adrs", rd_adrs, 32'h1010_0000);
      chk("r1_len", rd_len, 32'd614400);
      chk("r1_idx", {30'd0, rd_buf_idx}, 32'd1);
      chk("r1_repeat", {16'd0, repeat_cnt}, 32'd1);

      // Continuous writes while buffer 1 is on display never touch buffer 1.
      for (int i = 0; i < 5; i++) begin
         pulse_wr_sync();
         chk($sformatf("cw%0d_start", i), {31'd0, wr_start}, 32'd1);
         chk($sformatf("cw%0d_idx", i), {30'd0, wr_buf_idx}, {30'd0, wr_seq[i]});
         chk($sformatf("cw%0d_adrs", i), wr_adrs, adr_tab[wr_seq[i]]);
         if (i == 2) begin
            pulse_rd_sync();
            chk("rbusy_sync_repeat", {16'd0, repeat_cnt}, 32'd2);
            chk("rbusy_sync_no_start", {31'd0, rd_start}, 32'd0);
         end
         pulse_wr_done();
      end
      chk("cw_rd_held", rd_adrs, 32'h1010_0000);

      pulse_rd_done();
      pulse_rd_sync();
      chk("r2_start", {31'd0, rd_start}, 32'd1);
      chk("r2_idx", {30'd0, rd_buf_idx}, 32'd0);
      chk("r2_adrs", rd_adrs, 32'h1000_0000);
      chk("r2_repeat", {16'd0, repeat_cnt}, 32'd2);

      // latest=0, rd=0: writer picks 1; then done and sync coincide.
      pulse_wr_sync();
      chk("w_same_idx", {30'd0, wr_buf_idx}, 32'd1);
      wr_done = 1'b1; wr_frame_sync = 1'b1;
      step();
      wr_done = 1'b0; wr_frame_sync = 1'b0;
      chk("same_cycle_drop", {16'd0, drop_cnt}, 32'd2);
      chk("same_cycle_no_start", {31'd0, wr_start}, 32'd0);
      pulse_rd_done();
      pulse_rd_sync();
      chk("r3_idx_latest", {30'd0, rd_buf_idx}, 32'd1);
      chk("r3_repeat", {16'd0, repeat_cnt}, 32'd2);

      // Abort mid-write: latest stays 1.
      pulse_wr_sync();
      chk("w_abort_idx", {30'd0, wr_buf_idx}, 32'd0);
      enable = 1'b0;
      step();
      chk("abort_mrst_hi", {31'd0, master_rst}, 32'd1);
      step();
      chk("abort_mrst_lo", {31'd0, master_rst}, 32'd0);
      enable = 1'b1;
      pulse_rd_done();
      pulse_rd_sync();
      chk("r4_prev_frame", {30'd0, rd_buf_idx}, 32'd1);
      chk("r4_repeat", {16'd0, repeat_cnt}, 32'd3);
      chk("r4_adrs", rd_adrs, 32'h1010_0000);

      pulse_wr_sync();
      chk("post_abort_start", {31'd0, wr_start}, 32'd1);
      chk("post_abort_idx", {30'd0, wr_buf_idx}, 32'd0);
      chk("post_abort_drop", {16'd0, drop_cnt}, 32'd2);
      pulse_wr_done();

      // Mover not ready: sync dropped.
      wr_ready = 1'b0;
      pulse_wr_sync();
      chk("notready_no_start", {31'd0, wr_start}, 32'd0);
      chk("notready_drop", {16'd0, drop_cnt}, 32'd3);
      chk("err_low", {31'd0, err}, 32'd0);
      wr_ready = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
